// File: rtl/escaner_digitos.sv
// escaner_digitos: time-multiplexing digit scanner for multi-digit 7-segment
// displays. Each enabled digit owns one slot of DIGIT_CYCLES cycles. The first
// BLANK_CYCLES cycles of a slot keep every anode off so the segment data can
// settle (anti-ghosting). Masked-off digits are skipped. DigitIdx selects the
// segment data and changes only on the first cycle of a slot.
module escaner_digitos #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int IDXW        = $clog2(NUM_DIGITS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [NUM_DIGITS-1:0] DigitMask,
    output logic [NUM_DIGITS-1:0] Anodes,
    output logic [IDXW-1:0]       DigitIdx,
    output logic                  SlotStart
);

    localparam int CNTW = $clog2(DIGIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    // With no blanking interval a slot opens directly in SHOW.
    localparam state_t FIRST_STATE = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

    localparam logic [CNTW-1:0] DIGIT_LAST = CNTW'(DIGIT_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF =
        ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    slot_start_q, slot_start_d;
    logic [NUM_DIGITS-1:0]   sel_onehot;

    // Next enabled digit after cur, searching upward with wrap-around. The
    // final iteration revisits cur itself, so a single enabled digit repeats.
    // Starting from the last index yields the lowest set bit.
    function automatic logic [IDXW-1:0] next_set(input logic [NUM_DIGITS-1:0] mask,
                                                 input logic [IDXW-1:0]       cur);
        logic [IDXW-1:0] res;
        logic [IDXW-1:0] j;
        logic            found;
        res   = cur;
        found = 1'b0;
        for (int off = 1; off <= NUM_DIGITS; off++) begin
            j = IDXW'((int'(cur) + off) % NUM_DIGITS);
            if (!found && mask[j]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next-state logic and output decode of the next state, so the outputs
    // can be registered alongside the state and never see the inputs directly.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sel_onehot = '0;

        if (!Enable || (DigitMask == '0)) begin
            // Display off; idx is kept so the scan position is not lost.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = FIRST_STATE;
                    idx_d   = next_set(DigitMask, LAST_IDX);
                    cnt_d   = '0;
                end
                S_BLANK, S_SHOW: begin
                    if (!DigitMask[idx_q]) begin
                        // Current digit was masked off: abandon this slot.
                        state_d = FIRST_STATE;
                        idx_d   = next_set(DigitMask, idx_q);
                        cnt_d   = '0;
                    end else if (state_q == S_BLANK) begin
                        cnt_d = cnt_q + CNTW'(1);
                        if (cnt_q == BLANK_LAST) begin
                            state_d = S_SHOW;
                        end
                    end else if (cnt_q == DIGIT_LAST) begin
                        state_d = FIRST_STATE;
                        idx_d   = next_set(DigitMask, idx_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_d == S_SHOW) begin
            sel_onehot[idx_d] = 1'b1;
        end
        anodes_d     = ACTIVE_LOW ? ~sel_onehot : sel_onehot;
        slot_start_d = (state_d != S_IDLE) && (cnt_d == '0);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every flop loads from values
        // computed before this edge, independent of statement order.
        if (Reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            anodes_q     <= ANODES_OFF;
            slot_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            anodes_q     <= anodes_d;
            slot_start_q <= slot_start_d;
        end
    end

    assign Anodes    = anodes_q;
    assign DigitIdx  = idx_q;
    assign SlotStart = slot_start_q;

endmodule

// File: tb/tb_escaner_digitos.sv
// Testbench for escaner_digitos. Three instances share one stimulus:
// blanking of 2 cycles (active-low), no blanking (active-low), and blanking
// of 2 cycles (active-high). A slot-level model (owner digit + position in
// slot) predicts every output of every instance each cycle.
module tb_escaner_digitos;

    localparam int ND = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic [ND-1:0] DigitMask;

    logic [ND-1:0] an_b2, an_b0, an_hi;
    logic [1:0]    idx_b2, idx_b0, idx_hi;
    logic          ss_b2, ss_b0, ss_hi;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: is a scan running, which digit owns the slot, and the
    // position (0..DC-1) within that slot.
    bit m_run = 1'b0;
    int m_dig = 0;
    int m_pos = 0;

    always #5 clk = ~clk;

    escaner_digitos #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) u_b2 (
        .Clock(clk), .Reset(Reset), .Enable(Enable), .DigitMask(DigitMask),
        .Anodes(an_b2), .DigitIdx(idx_b2), .SlotStart(ss_b2));

    escaner_digitos #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) u_b0 (
        .Clock(clk), .Reset(Reset), .Enable(Enable), .DigitMask(DigitMask),
        .Anodes(an_b0), .DigitIdx(idx_b0), .SlotStart(ss_b0));

    escaner_digitos #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0)) u_hi (
        .Clock(clk), .Reset(Reset), .Enable(Enable), .DigitMask(DigitMask),
        .Anodes(an_hi), .DigitIdx(idx_hi), .SlotStart(ss_hi));

    function automatic bit has(input logic [ND-1:0] mask, input int d);
        return ((mask >> d) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int lowest(input logic [ND-1:0] mask);
        for (int i = 0; i < ND; i++) if (has(mask, i)) return i;
        return 0;
    endfunction

    function automatic int following(input logic [ND-1:0] mask, input int cur);
        for (int k = 1; k <= ND; k++) if (has(mask, (cur + k) % ND)) return (cur + k) % ND;
        return cur;
    endfunction

    function automatic logic [ND-1:0] exp_anodes(input int blank, input bit act_low);
        logic [ND-1:0] a;
        a = (m_run && m_pos >= blank) ? (4'b0001 << m_dig) : 4'b0000;
        return act_low ? ~a : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic model_step();
        if (Reset) begin
            m_run = 1'b0; m_dig = 0; m_pos = 0;
        end else if (!Enable || DigitMask == '0) begin
            m_run = 1'b0; m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_dig = lowest(DigitMask); m_pos = 0;
        end else if (!has(DigitMask, m_dig) || m_pos == DC - 1) begin
            m_dig = following(DigitMask, m_dig); m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_all();
        bit ss;
        ss = m_run && (m_pos == 0);
        chk("anodes_b2", 32'(an_b2), 32'(exp_anodes(2, 1'b1)));
        chk("idx_b2",    32'(idx_b2), 32'(m_dig));
        chk("slot_b2",   32'(ss_b2), 32'(ss));
        chk("anodes_b0", 32'(an_b0), 32'(exp_anodes(0, 1'b1)));
        chk("idx_b0",    32'(idx_b0), 32'(m_dig));
        chk("slot_b0",   32'(ss_b0), 32'(ss));
        chk("anodes_hi", 32'(an_hi), 32'(exp_anodes(2, 1'b0)));
        chk("idx_hi",    32'(idx_hi), 32'(m_dig));
        chk("slot_hi",   32'(ss_hi), 32'(ss));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_slot(input int dig, input int pos, input string tag);
        int n;
        n = 0;
        while (!(m_run && m_dig == dig && m_pos == pos) && n < 100) begin
            step();
            n++;
        end
        chk(tag, 32'(m_run && m_dig == dig && m_pos == pos), 32'd1);
    endtask

    initial begin
        int r;
        Reset = 1'b1; Enable = 1'b0; DigitMask = '0;
        @(negedge clk);
        step();
        step();
        chk("reset_anodes", 32'(an_b2), 32'h0000000f);
        chk("reset_idx",    32'(idx_b2), 32'd0);
        chk("reset_slot",   32'(ss_b2), 32'd0);
        chk("reset_anodes_hi", 32'(an_hi), 32'h00000000);
        Reset = 1'b0;
        step();

        // Full scan of all four digits.
        Enable = 1'b1; DigitMask = 4'b1111;
        step();
        chk("start_slot", 32'(ss_b2), 32'd1);
        chk("start_idx",  32'(idx_b2), 32'd0);
        repeat (40) step();

        // Alternate digits, then a single digit.
        DigitMask = 4'b1010;
        repeat (40) step();
        DigitMask = 4'b0100;
        repeat (24) step();

        // Mask abort: drop digit 1 while it is shown at slot cycle 4.
        DigitMask = 4'b1111;
        wait_slot(1, 4, "wait_abort_point");
        DigitMask = 4'b1101;
        step();
        chk("abort_slot",   32'(ss_b2), 32'd1);
        chk("abort_idx",    32'(idx_b2), 32'd2);
        chk("abort_anodes", 32'(an_b2), 32'h0000000f);
        step();
        chk("abort_blank2", 32'(an_b2), 32'h0000000f);
        step();
        chk("abort_show",   32'(an_b2), 32'h0000000b);

        // Disable mid-SHOW, then re-enable.
        wait_slot(2, 5, "wait_disable_point");
        Enable = 1'b0;
        repeat (4) begin
            step();
            chk("disabled_anodes", 32'(an_b2), 32'h0000000f);
        end
        Enable = 1'b1;
        step();
        chk("reenable_slot", 32'(ss_b2), 32'd1);
        chk("reenable_idx",  32'(idx_b2), 32'd0);
        chk("reenable_noblank_anodes", 32'(an_b0), 32'h0000000e);
        repeat (10) step();

        // Reset mid-SHOW of digit 2.
        wait_slot(2, 5, "wait_reset_point");
        Reset = 1'b1;
        step();
        chk("midreset_anodes", 32'(an_b2), 32'h0000000f);
        chk("midreset_idx",    32'(idx_b2), 32'd0);
        chk("midreset_slot",   32'(ss_b2), 32'd0);
        chk("midreset_anodes_b0", 32'(an_b0), 32'h0000000f);
        Reset = 1'b0;
        step();

        // Randomised mask/enable/reset activity.
        for (int i = 0; i < 700; i++) begin
            Reset = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                DigitMask = 4'($urandom_range(0, 15));
            end else if (r < 7) begin
                DigitMask = DigitMask & ~(4'b0001 << m_dig);
            end else if (r < 9) begin
                Enable = 1'b0;
            end else if (r < 20) begin
                Enable = 1'b1;
                if (DigitMask == '0) DigitMask = 4'($urandom_range(1, 15));
            end else if (r == 20) begin
                Reset = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/escaner_digitos.md
# escaner_digitos

Parametrised time-multiplexing scanner for common-anode/cathode multi-digit 7-segment displays. It generalises the fixed 4-digit selector with:

- configurable digit count, slot length and output polarity;
- a per-slot blanking interval that suppresses ghosting;
- a runtime digit-enable mask, with skipping of masked digits;
- an index output that drives the segment-data mux.

It sits between the clock/reset tree and the display pins, alongside the BCD-to-segment decoder in the digital clock top level.

## Interface

Parameters:

- NUM_DIGITS, 4, number of digits scanned; legal range 2..16
- DIGIT_CYCLES, 100000, clock cycles per digit slot; must be at least 2
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be less than DIGIT_CYCLES; 0 means no blanking
- ACTIVE_LOW, 1, when 1 the active anode is driven 0 and inactive anodes 1; when 0, the reverse
- IDXW, derived as $clog2(NUM_DIGITS), width of DigitIdx

Ports:

- Clock, input, 1, sole clock; all logic on the rising edge
- Reset, input, 1, synchronous, active-high
- Enable, input, 1, scan enable; 0 forces the display off
- DigitMask, input, NUM_DIGITS, bit i=1 includes digit i in the scan
- Anodes, output, NUM_DIGITS, one-hot (ACTIVE_LOW=0) or one-cold (ACTIVE_LOW=1) digit select
- DigitIdx, output, IDXW, index of the digit owning the current slot; used for the segment mux
- SlotStart, output, 1, high for exactly the first cycle of every slot

## Operation

- State registers:
  - state: IDLE, BLANK or SHOW;
  - idx, of width IDXW;
  - cnt, of width $clog2(DIGIT_CYCLES).
- All outputs are decoded only from these registers. Outputs have no combinational path from the inputs.
- IDLE:
  - Anodes are all inactive and cnt is held at 0.
  - When Enable=1 and DigitMask is non-zero, go to BLANK (or to SHOW if BLANK_CYCLES=0).
  - On that entry, idx is set to the lowest set bit of DigitMask, cnt=0 and SlotStart=1.
- BLANK:
  - Anodes are all inactive and cnt increments.
  - When cnt==BLANK_CYCLES-1, go to SHOW.
- SHOW:
  - Anodes[idx] is active and all other anodes are inactive. cnt increments.
  - When cnt==DIGIT_CYCLES-1, advance to the next slot.
- Advancing to the next slot:
  - idx becomes the next set bit of DigitMask, searching idx+1 upward and wrapping past NUM_DIGITS-1 to 0.
  - If only the current digit is enabled, idx repeats.
  - cnt resets to 0, SlotStart=1, and the state becomes BLANK (or SHOW if BLANK_CYCLES=0).
- Mask change mid-slot:
  - If DigitMask[idx] goes to 0 while in BLANK or SHOW, the current slot is aborted.
  - The next cycle starts a new slot on the next enabled digit, as for a normal advance.
  - If the mask became all zero, go to IDLE instead.
  - Mask changes to other bits take effect at the next advance only.
- Enable=0, or DigitMask==0, in any state: go to IDLE on the next cycle. idx is retained.
- Priority, highest first: Reset, then (Enable=0 or mask all zero), then mask abort, then the normal transition.

## Timing

- Reset values, one cycle after Reset is sampled high:
  - state=IDLE, idx=0, cnt=0;
  - Anodes all inactive (all 1s when ACTIVE_LOW=1, all 0s when ACTIVE_LOW=0);
  - DigitIdx=0, SlotStart=0.
- Reset asserted mid-slot has the same effect; no partial slot resumes.
- Start-up latency: the first slot begins on the cycle after Enable=1 and a non-zero mask are first sampled in IDLE.
- Slot length is exactly DIGIT_CYCLES cycles. Cycles 0..BLANK_CYCLES-1 are blank; cycles BLANK_CYCLES..DIGIT_CYCLES-1 show the digit.
- A full scan with k enabled digits lasts k*DIGIT_CYCLES cycles. Scan order is ascending with wrap-around.
- DigitIdx changes only on the SlotStart cycle. It therefore leads the anode by BLANK_CYCLES cycles, which gives the segment path time to settle.
- At most one anode is active in any cycle. No cycle ever has an anode active while DigitIdx differs from that anode's index.

## Test plan

Bench parameters: NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, ACTIVE_LOW=1.

- Reset, then Enable=1, DigitMask=4'b1111.
  - Anodes=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101 for 6 cycles, and so on.
  - DigitIdx runs 0,1,2,3,0. SlotStart pulses every 8 cycles.
- DigitMask=4'b1010.
  - Only 1101 and 0111 appear. DigitIdx alternates 1,3 and the period is 16 cycles.
- DigitMask=4'b0100: Anodes alternate 1111 (2 cycles) and 1011 (6 cycles). SlotStart pulses every 8 cycles with DigitIdx=2.
- Clear DigitMask[idx] at slot cycle 4 while showing digit 1, mask going 1111 to 1101.
  - Next cycle is a new slot with DigitIdx=2, SlotStart=1 and Anodes=1111 for 2 cycles.
- Enable to 0 mid-SHOW: Anodes=1111 on the next cycle and stays there.
  - Re-enable: a slot starts on the lowest enabled digit one cycle later.
- Reset mid-SHOW of digit 2: the next cycle has Anodes=1111, DigitIdx=0 and SlotStart=0.
  - Rerun with BLANK_CYCLES=0: the anode is active on the SlotStart cycle itself and no blank gap appears.
